// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: UART command sequencer between the RX byte stream and the RegFile/ALU datapath.
// Decodes AA/BB/CC/DD frames, drives registered RF/ALU strobes and pushes result bytes to TX.
module sys_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam logic [DATA_WIDTH-1:0] OpRfWrite = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OpRfRead  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OpAluOps  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OpAluNop  = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StAluA,
        StAluB,
        StAluFun,
        StAluWait,
        StTxByte,
        StTxLsb,
        StTxMsb
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [2*DATA_WIDTH-1:0] alu_res_q;

    logic [ADDR_WIDTH-1:0]   rx_addr;
    logic [FUN_WIDTH-1:0]    rx_fun;

    assign rx_addr = RX_P_DATA[ADDR_WIDTH-1:0];
    assign rx_fun  = RX_P_DATA[FUN_WIDTH-1:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rd_data_q   <= '0;
            alu_res_q   <= '0;
            RF_ADDR     <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            RF_WR_DATA  <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            // Strobes are single-cycle; data outputs hold their last value.
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            OpRfWrite: state_q <= StWrAddr;
                            OpRfRead:  state_q <= StRdAddr;
                            OpAluOps:  state_q <= StAluA;
                            OpAluNop:  state_q <= StAluFun;
                            default:   state_q <= StIdle;
                        endcase
                    end
                end
                StWrAddr: begin
                    if (RX_D_VLD) begin
                        addr_q  <= rx_addr;
                        state_q <= StWrData;
                    end
                end
                StWrData: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= addr_q;
                        RF_WR_DATA <= RX_P_DATA;
                        state_q    <= StIdle;
                    end
                end
                StRdAddr: begin
                    if (RX_D_VLD) begin
                        RF_RD_EN <= 1'b1;
                        RF_ADDR  <= rx_addr;
                        state_q  <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (RF_RD_DATA_VLD) begin
                        rd_data_q <= RF_RD_DATA;
                        state_q   <= StTxByte;
                    end
                end
                StAluA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= ADDR_WIDTH'(0);
                        RF_WR_DATA <= RX_P_DATA;
                        state_q    <= StAluB;
                    end
                end
                StAluB: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= ADDR_WIDTH'(1);
                        RF_WR_DATA <= RX_P_DATA;
                        state_q    <= StAluFun;
                    end
                end
                StAluFun: begin
                    if (RX_D_VLD) begin
                        ALU_EN      <= 1'b1;
                        ALU_FUN     <= rx_fun;
                        CLK_GATE_EN <= 1'b1;
                        state_q     <= StAluWait;
                    end
                end
                StAluWait: begin
                    // Gate stays open through the cycle the result arrives.
                    if (ALU_OUT_VLD) begin
                        alu_res_q   <= ALU_OUT;
                        CLK_GATE_EN <= 1'b0;
                        state_q     <= StTxLsb;
                    end
                end
                StTxByte: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= rd_data_q;
                        state_q   <= StIdle;
                    end
                end
                StTxLsb: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= alu_res_q[DATA_WIDTH-1:0];
                        state_q   <= StTxMsb;
                    end
                end
                StTxMsb: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
